// File: rtl/mouse_shot_if.sv
// Mouse/VGA-side inputs plus cursor position and shot handshake toward the draw and hit stages.
interface mouse_shot_if;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        mouse_left;
  logic        vblnk;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        shot_valid;
  logic        shot_ready;
  logic [11:0] shot_x;
  logic [11:0] shot_y;
  logic        reloading;

  // The stage itself.
  modport slave (
    input  mouse_xpos, mouse_ypos, mouse_left, vblnk, shot_ready,
    output xpos, ypos, shot_valid, shot_x, shot_y, reloading
  );

  // Whatever drives the stage and consumes its outputs.
  modport master (
    output mouse_xpos, mouse_ypos, mouse_left, vblnk, shot_ready,
    input  xpos, ypos, shot_valid, shot_x, shot_y, reloading
  );
endinterface

// File: rtl/mouse_shot_ctrl.sv
// Frame-latched, clamped cursor position plus a one-shot trigger with a valid/ready handshake.
// Each accepted shot is followed by a reload cooldown that is counted in frames.
module mouse_shot_ctrl #(
  parameter int H_RES           = 800,
  parameter int V_RES           = 600,
  parameter int COOLDOWN_FRAMES = 15,
  parameter int CNT_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  mouse_shot_if.slave bus
);
  localparam logic [11:0]      X_MAX   = 12'(H_RES - 1);
  localparam logic [11:0]      Y_MAX   = 12'(V_RES - 1);
  localparam logic [11:0]      X_RST   = 12'(H_RES / 2);
  localparam logic [11:0]      Y_RST   = 12'(V_RES / 2);
  localparam logic [CNT_W-1:0] CNT_CD  = CNT_W'(COOLDOWN_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {ARMED, SHOT, COOLDOWN} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              vblnk_q, btn_s1, btn_s2, btn_q;
  logic              tick, rise;
  logic [11:0]       xpos_r, ypos_r, x_clamp, y_clamp;
  logic              shot_valid_r, shot_valid_n;
  logic [11:0]       shot_x_r, shot_x_n, shot_y_r, shot_y_n;
  logic              reloading_r, reloading_n;

  assign tick    = bus.vblnk & ~vblnk_q;
  assign rise    = btn_s2 & ~btn_q;
  assign x_clamp = (bus.mouse_xpos > X_MAX) ? X_MAX : bus.mouse_xpos;
  assign y_clamp = (bus.mouse_ypos > Y_MAX) ? Y_MAX : bus.mouse_ypos;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARMED;
      cnt          <= '0;
      vblnk_q      <= 1'b0;
      btn_s1       <= 1'b0;
      btn_s2       <= 1'b0;
      btn_q        <= 1'b0;
      xpos_r       <= X_RST;
      ypos_r       <= Y_RST;
      shot_valid_r <= 1'b0;
      shot_x_r     <= '0;
      shot_y_r     <= '0;
      reloading_r  <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      vblnk_q      <= bus.vblnk;
      btn_s1       <= bus.mouse_left;
      btn_s2       <= btn_s1;
      btn_q        <= btn_s2;
      shot_valid_r <= shot_valid_n;
      shot_x_r     <= shot_x_n;
      shot_y_r     <= shot_y_n;
      reloading_r  <= reloading_n;
      if (tick) begin
        xpos_r <= x_clamp;
        ypos_r <= y_clamp;
      end
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    shot_valid_n = shot_valid_r;
    shot_x_n     = shot_x_r;
    shot_y_n     = shot_y_r;
    case (state)
      ARMED: begin
        // Captures the pre-tick position even if a tick lands on the same edge.
        if (rise) begin
          shot_valid_n = 1'b1;
          shot_x_n     = xpos_r;
          shot_y_n     = ypos_r;
          state_n      = SHOT;
        end
      end
      SHOT: begin
        if (shot_valid_r && bus.shot_ready) begin
          shot_valid_n = 1'b0;
          if (COOLDOWN_FRAMES == 0) begin
            state_n = ARMED;
          end else begin
            cnt_n   = CNT_CD;
            state_n = COOLDOWN;
          end
        end
      end
      COOLDOWN: begin
        if (tick) begin
          cnt_n = cnt - CNT_ONE;
          if (cnt == CNT_ONE) state_n = ARMED;
        end
      end
      default: state_n = ARMED;
    endcase
    reloading_n = (state_n == SHOT) || (state_n == COOLDOWN);
  end

  assign bus.xpos       = xpos_r;
  assign bus.ypos       = ypos_r;
  assign bus.shot_valid = shot_valid_r;
  assign bus.shot_x     = shot_x_r;
  assign bus.shot_y     = shot_y_r;
  assign bus.reloading  = reloading_r;
endmodule

// File: tb/tb_mouse_shot_ctrl.sv
// Directed scenarios plus randomized traffic, checked every cycle against a frame/shot-level model.
module tb_mouse_shot_ctrl;
  localparam int H_RES = 800;
  localparam int V_RES = 600;
  localparam int CD    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mouse_shot_if bus();

  mouse_shot_ctrl #(.H_RES(H_RES), .V_RES(V_RES), .COOLDOWN_FRAMES(CD), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: current cursor, a pending-shot flag and the number of frames of reload left.
  int m_x, m_y, m_sx, m_sy, m_left;
  bit m_pend, model_ok = 1'b0;
  bit h1, h2, h3, vb_prev;

  function automatic int clampv(input int v, input int lim);
    return (v > lim - 1) ? lim - 1 : v;
  endfunction

  always @(posedge clk) begin
    int  px, py;
    bit  tk, rs;
    if (rst) begin
      m_x = H_RES / 2; m_y = V_RES / 2; m_sx = 0; m_sy = 0;
      m_pend = 0; m_left = 0; h1 = 0; h2 = 0; h3 = 0; vb_prev = 0;
      model_ok = 1;
    end else begin
      tk = bus.vblnk && !vb_prev;
      // Button sampled two edges ago is high, three edges ago low.
      rs = h2 && !h3;
      px = m_x; py = m_y;
      if (tk) begin
        m_x = clampv(int'(bus.mouse_xpos), H_RES);
        m_y = clampv(int'(bus.mouse_ypos), V_RES);
      end
      if (m_pend) begin
        if (bus.shot_ready) begin
          m_pend = 0;
          m_left = CD;
        end
      end else if (m_left > 0) begin
        if (tk) m_left--;
      end else if (rs) begin
        m_pend = 1; m_sx = px; m_sy = py;
      end
      h3 = h2; h2 = h1; h1 = bus.mouse_left; vb_prev = bus.vblnk;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("xpos", int'(bus.xpos), m_x);
      check("ypos", int'(bus.ypos), m_y);
      check("shot_valid", int'(bus.shot_valid), int'(m_pend));
      check("shot_x", int'(bus.shot_x), m_sx);
      check("shot_y", int'(bus.shot_y), m_sy);
      check("reloading", int'(bus.reloading), int'(m_pend || m_left > 0));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    bus.vblnk = 1'b1; cyc(1);
    bus.vblnk = 1'b0; cyc(1);
  endtask

  task automatic click();
    bus.mouse_left = 1'b1; cyc(4);
    bus.mouse_left = 1'b0; cyc(3);
  endtask

  task automatic handshake();
    bus.shot_ready = 1'b1; cyc(1);
    bus.shot_ready = 1'b0;
  endtask

  initial begin
    bus.mouse_xpos = '0; bus.mouse_ypos = '0; bus.mouse_left = 1'b0;
    bus.vblnk = 1'b0; bus.shot_ready = 1'b0;
    cyc(3);
    rst = 1'b0;
    check("rst_xpos", int'(bus.xpos), 400);
    check("rst_ypos", int'(bus.ypos), 300);
    check("rst_valid", int'(bus.shot_valid), 0);
    check("rst_reload", int'(bus.reloading), 0);

    bus.mouse_xpos = 12'd900; bus.mouse_ypos = 12'd650;
    frame();
    check("clamp_x", int'(bus.xpos), 799);
    check("clamp_y", int'(bus.ypos), 599);
    bus.mouse_xpos = 12'd100; bus.mouse_ypos = 12'd200;
    cyc(5);
    check("hold_x", int'(bus.xpos), 799);
    check("hold_y", int'(bus.ypos), 599);

    bus.mouse_xpos = 12'd320; bus.mouse_ypos = 12'd240;
    frame();
    bus.mouse_left = 1'b1;
    cyc(2);
    check("lat_early", int'(bus.shot_valid), 0);
    cyc(1);
    check("lat_valid", int'(bus.shot_valid), 1);
    check("cap_x", int'(bus.shot_x), 320);
    check("cap_y", int'(bus.shot_y), 240);
    check("lat_reload", int'(bus.reloading), 1);

    for (int i = 0; i < 50; i++) begin
      bus.mouse_xpos = 12'($urandom_range(0, 1023));
      bus.mouse_ypos = 12'($urandom_range(0, 1023));
      bus.vblnk      = (i % 10 == 0);
      cyc(1);
    end
    bus.vblnk = 1'b0; bus.mouse_left = 1'b0;
    check("bp_valid", int'(bus.shot_valid), 1);
    check("bp_x", int'(bus.shot_x), 320);
    check("bp_y", int'(bus.shot_y), 240);
    handshake();
    check("hs_valid", int'(bus.shot_valid), 0);
    check("hs_reload", int'(bus.reloading), 1);

    frame(); click(); frame(); click();
    check("cd_valid", int'(bus.shot_valid), 0);
    check("cd_reload", int'(bus.reloading), 1);
    frame();
    check("cd_done", int'(bus.reloading), 0);
    bus.mouse_left = 1'b1; cyc(3);
    check("cd_fire", int'(bus.shot_valid), 1);

    handshake();
    frame(); frame(); frame(); cyc(4);
    check("held_valid", int'(bus.shot_valid), 0);
    check("held_reload", int'(bus.reloading), 0);
    bus.mouse_left = 1'b0; cyc(3);
    bus.mouse_left = 1'b1; cyc(3);
    check("refire", int'(bus.shot_valid), 1);
    bus.mouse_left = 1'b0;
    handshake();
    frame();
    rst = 1'b1; cyc(1); rst = 1'b0;
    check("mr_xpos", int'(bus.xpos), 400);
    check("mr_ypos", int'(bus.ypos), 300);
    check("mr_reload", int'(bus.reloading), 0);
    check("mr_valid", int'(bus.shot_valid), 0);
    bus.mouse_left = 1'b1; cyc(3);
    check("mr_fire", int'(bus.shot_valid), 1);
    bus.mouse_left = 1'b0;
    handshake();

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        bus.mouse_xpos = 12'($urandom_range(0, 1023));
        bus.mouse_ypos = 12'($urandom_range(0, 1023));
      end else begin
        bus.mouse_xpos = 12'($urandom_range(0, 4095));
        bus.mouse_ypos = 12'($urandom_range(0, 4095));
      end
      bus.vblnk = ((i % 24) < 2);
      if ($urandom_range(0, 7) == 0) bus.mouse_left = ~bus.mouse_left;
      bus.shot_ready = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    rst = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
